word_display_renderer: RTL

//   Parametrised successor of the hangman word display: a framebuffer painter that writes the

---
 rtl/word_display_renderer_if.sv | 26 ++
 rtl/word_display_renderer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/word_display_renderer_if.sv
// Signal bundle between the game FSM, the glyph ROM and vga_adapter.
// The master side is the word display renderer.
interface word_display_renderer_if #(
    parameter int NUM_SLOTS = 6
);
    logic [1:0]             game_state;
    logic [5*NUM_SLOTS-1:0] word;
    logic [25:0]            mask;
    logic [4:0]             glyph_code;
    logic [63:0]            glyph_bits;
    logic [8:0]             x;
    logic [7:0]             y;
    logic [2:0]             colour;
    logic                   plot;
    logic                   frame_done;

    modport master (
        input  game_state, word, mask, glyph_bits,
        output glyph_code, x, y, colour, plot, frame_done
    );

    modport slave (
        output game_state, word, mask, glyph_bits,
        input  glyph_code, x, y, colour, plot, frame_done
    );
endinterface

// File: rtl/word_display_renderer.sv
// Framebuffer painter for the hidden word: screen clear on every game
// state change, then back-to-back redraws of the glyph/dash box.
module word_display_renderer #(
    parameter int         NUM_SLOTS  = 6,
    parameter int         X0         = 20,
    parameter int         SLOT_PITCH = 10,
    parameter int         Y_LETTER   = 200,
    parameter int         Y_DASH     = 210,
    parameter int         SCR_W      = 320,
    parameter int         SCR_H      = 240,
    parameter int         DASH_CODE  = 27,
    parameter logic [2:0] BG_COLOUR  = 3'b000
) (
    input  logic                    clk,
    input  logic                    resetn,
    word_display_renderer_if.master bus
);
    localparam int         WW    = 5 * NUM_SLOTS;
    localparam logic [8:0] XMAX  = 9'(SCR_W - 1);
    localparam logic [7:0] YMAX  = 8'(SCR_H - 1);
    localparam logic [8:0] BX0   = 9'(X0);
    localparam logic [8:0] BX1   = 9'(X0 + NUM_SLOTS * SLOT_PITCH - 1);
    localparam logic [7:0] BY0   = 8'(Y_LETTER);
    localparam logic [7:0] BY1   = 8'(Y_DASH + 7);
    localparam logic [7:0] DY0   = 8'(Y_DASH);
    localparam logic [8:0] PITCH = 9'(SLOT_PITCH);

    typedef enum logic [1:0] {S_CLEAR, S_DRAW, S_HOLD} state_t;

    state_t          r_state;
    logic [1:0]      r_gs;
    logic [8:0]      r_sx;
    logic [7:0]      r_sy;
    logic [WW-1:0]   r_word;
    logic [25:0]     r_mask;
    logic [2:0]      r_fg;
    logic [8:0]      r_x;
    logic [7:0]      r_y;
    logic            r_plot;
    logic            r_done;
    logic            r_en;
    logic [5:0]      r_bit;

    logic            w_chg;
    logic            w_first;
    logic            w_clr_last;
    logic            w_drw_last;
    logic [WW-1:0]   w_word;
    logic [31:0]     w_mask;
    logic [8:0]      w_dx;
    logic [8:0]      w_slot;
    logic [8:0]      w_cx;
    logic [7:0]      w_dl;
    logic [7:0]      w_dd;
    logic            w_let;
    logic            w_dash;
    logic [4:0]      w_code;
    logic            w_known;
    logic            w_en;
    logic [5:0]      w_bit;
    logic [4:0]      w_gc;
    logic [2:0]      w_fg;

    // Stage-0 pixel decode: slot, glyph cell, ROM address and lit enable
    always_comb begin
        w_chg      = bus.game_state != r_gs;
        w_first    = (r_state == S_DRAW) && (r_sx == BX0) && (r_sy == BY0);
        w_clr_last = (r_sx == XMAX) && (r_sy == YMAX);
        w_drw_last = (r_sx == BX1) && (r_sy == BY1);
        w_word     = w_first ? bus.word : r_word;
        w_mask     = {6'd0, (w_first ? bus.mask : r_mask)};
        w_dx       = r_sx - BX0;
        w_slot     = w_dx / PITCH;
        w_cx       = w_dx % PITCH;
        w_dl       = r_sy - BY0;
        w_dd       = r_sy - DY0;
        w_let      = w_dl < 8'd8;
        w_dash     = w_dd < 8'd8;
        w_code     = 5'd31;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_slot == 9'(i))
                w_code = w_word[5*(NUM_SLOTS-1-i) +: 5];
        end
        // Empty slots (code >= 26) never reach the mask lookup
        w_known = w_code < 5'd26;
        w_bit   = {w_cx[2:0], (w_let ? w_dl[2:0] : w_dd[2:0])};
        w_en    = (r_state == S_DRAW) && (w_cx < 9'd8) && w_known &&
                  (w_dash || (w_let && (w_mask[w_code] || r_gs != 2'd1)));
        w_gc    = 5'd0;
        if (r_state == S_DRAW) begin
            unique case (1'b1)
                w_let:   w_gc = w_code;
                w_dash:  w_gc = 5'(DASH_CODE);
                default: w_gc = 5'd0;
            endcase
        end
        unique case (r_gs)
            2'd1:    w_fg = 3'b111;
            2'd2:    w_fg = 3'b010;
            2'd3:    w_fg = 3'b100;
            default: w_fg = 3'b000;
        endcase
    end

    // Scan FSM (stage 0) and registered pixel outputs (stage 1)
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_CLEAR;
            r_gs    <= bus.game_state;
            r_sx    <= '0;
            r_sy    <= '0;
            r_word  <= '0;
            r_mask  <= '0;
            r_fg    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_plot  <= 1'b0;
            r_done  <= 1'b0;
            r_en    <= 1'b0;
            r_bit   <= '0;
        end else begin
            if (r_state == S_HOLD) begin
                r_plot <= 1'b0;
                r_done <= 1'b0;
                r_en   <= 1'b0;
            end else begin
                r_x    <= r_sx;
                r_y    <= r_sy;
                r_plot <= 1'b1;
                r_en   <= w_en;
                r_bit  <= w_bit;
                r_done <= (r_state == S_CLEAR) ? w_clr_last : w_drw_last;
            end
            if (w_first) begin
                r_word <= bus.word;
                r_mask <= bus.mask;
                r_fg   <= w_fg;
            end
            if (w_chg) begin
                r_gs    <= bus.game_state;
                r_state <= S_CLEAR;
                r_sx    <= '0;
                r_sy    <= '0;
            end else begin
                unique case (r_state)
                    S_CLEAR: begin
                        if (w_clr_last) begin
                            r_state <= (r_gs == 2'd0) ? S_HOLD : S_DRAW;
                            r_sx    <= BX0;
                            r_sy    <= BY0;
                        end else if (r_sx == XMAX) begin
                            r_sx <= '0;
                            r_sy <= r_sy + 8'd1;
                        end else begin
                            r_sx <= r_sx + 9'd1;
                        end
                    end
                    S_DRAW: begin
                        if (r_sx == BX1) begin
                            r_sx <= BX0;
                            r_sy <= (r_sy == BY1) ? BY0 : r_sy + 8'd1;
                        end else begin
                            r_sx <= r_sx + 9'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.glyph_code = w_gc;
    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.plot       = r_plot;
    assign bus.frame_done = r_done;
    // ROM data arrives one cycle after the address, in step with stage 1
    assign bus.colour     = (r_en && bus.glyph_bits[r_bit]) ? r_fg : BG_COLOUR;
endmodule
